// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the sized data memory
// Purpose: access-size and FSM state enums, lane-count constants, and the
//          size helpers used by dmem_sized and dmem_lane_align.
// Ports:   none (package).
package dmem_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   localparam int LANES_B = 1;
   localparam int LANES_H = 2;
   localparam int LANES_W = 4;
   localparam int LANES_D = 8;

   // Number of byte lanes touched by an access of the given size.
   function automatic int lane_count(size_t s);
      case (s)
         SIZE_B:  return LANES_B;
         SIZE_H:  return LANES_H;
         SIZE_W:  return LANES_W;
         default: return LANES_D;
      endcase
   endfunction

   // A 32-bit memory has no dword lanes, so a dword request degrades to a word.
   function automatic size_t eff_size(logic [1:0] s, int n);
      if (n == 32 && s == 2'b11) return SIZE_W;
      return size_t'(s);
   endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// rtl/dmem_sized_if.sv - request/response bus of the sized data memory
// Purpose: groups the valid/ready request fields and the registered response.
// Ports (master = requester / LSU, slave = dmem_sized):
//   reqValid, writeEnable, size, signedLoad, addr, writeData : master -> slave
//   reqReady, respValid, readData, respErr                  : slave -> master
interface dmem_sized_if #(
   parameter int N = 32,
   parameter int R = 6
);
   localparam int AW = R + $clog2(N / 8);

   logic          reqValid;
   logic          reqReady;
   logic          writeEnable;
   logic [1:0]    size;
   logic          signedLoad;
   logic [AW-1:0] addr;
   logic [N-1:0]  writeData;
   logic          respValid;
   logic [N-1:0]  readData;
   logic          respErr;

   modport master (
      output reqValid, writeEnable, size, signedLoad, addr, writeData,
      input  reqReady, respValid, readData, respErr
   );

   modport slave (
      input  reqValid, writeEnable, size, signedLoad, addr, writeData,
      output reqReady, respValid, readData, respErr
   );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for sized loads and stores
// Purpose: combinational store byte mask / data shift and load lane extract
//          with sign or zero extension.
// Ports:
//   size_i   in  effective access size
//   off_i    in  byte offset within the word (already aligned as required)
//   signed_i in  1 = sign-extend load result
//   wdata_i  in  store data, right-justified
//   rword_i  in  memory word read for a load
//   wmask_o  out per-byte write enables
//   wdata_o  out store data moved onto its lanes
//   rdata_o  out extended load result
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int N  = 32,
   parameter int LW = $clog2(N / 8)
) (
   input  size_t           size_i,
   input  logic [LW-1:0]   off_i,
   input  logic            signed_i,
   input  logic [N-1:0]    wdata_i,
   input  logic [N-1:0]    rword_i,
   output logic [N/8-1:0]  wmask_o,
   output logic [N-1:0]    wdata_o,
   output logic [N-1:0]    rdata_o
);

   logic [LW+2:0]  shamt;
   logic [N/8-1:0] base_mask;
   logic [N-1:0]   shifted;
   logic [N-1:0]   keep;
   logic           sbit;
   int             nbytes;

   always_comb begin
      nbytes    = lane_count(size_i);
      shamt     = {off_i, 3'b000};
      base_mask = '0;
      keep      = '0;
      for (int i = 0; i < N / 8; i++) base_mask[i] = (i < nbytes);
      for (int i = 0; i < N; i++) keep[i] = (i < 8 * nbytes);

      wmask_o = base_mask << off_i;
      wdata_o = wdata_i << shamt;

      shifted = rword_i >> shamt;
      case (size_i)
         SIZE_B:  sbit = shifted[7];
         SIZE_H:  sbit = shifted[15];
         SIZE_W:  sbit = shifted[31];
         default: sbit = shifted[N-1];
      endcase
      // Bits above the access width are either the replicated sign bit or zero.
      rdata_o = (shifted & keep) | (~keep & {N{signed_i & sbit}});
   end

endmodule

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte-addressed sized data memory with valid/ready port
// Purpose: 2**r words of n bits; byte/half/word(/dword) loads and stores,
//          one request per three cycles, response two edges after acceptance.
// Config:  DMEM_MISALIGN_TRAP_EN - misaligned access reports respErr and
//          does not write; otherwise low address bits are aligned down.
// Ports:
//   clk_i    in  rising-edge clock
//   reset_i  in  asynchronous active-high reset (array contents retained)
//   bus      slave side of dmem_sized_if (request fields, response)
module dmem_sized
   import dmem_pkg::*;
#(
   parameter int n = 32,
   parameter int r = 6
) (
   input logic         clk_i,
   input logic         reset_i,
   dmem_sized_if.slave bus
);

   localparam int LW = $clog2(n / 8);
   localparam int AW = r + LW;
   localparam int NB = n / 8;

   state_t        state_q, state_d;
   logic          we_q;
   logic          sgn_q;
   size_t         size_q;
   logic [AW-1:0] addr_q;
   logic [n-1:0]  wdata_q;
   logic [n-1:0]  word_q;

   logic [n-1:0]  mem_q [2**r];

   logic          accept;
   logic [r-1:0]  word_idx;
   logic [LW-1:0] off_raw;
   logic [LW-1:0] amask;
   logic [LW-1:0] off_eff;
   logic          err;
   logic          mem_we;
   logic [NB-1:0] wmask;
   logic [n-1:0]  wdata_sh;
   logic [n-1:0]  load_data;

   assign accept   = bus.reqValid && (state_q == IDLE);
   assign word_idx = addr_q[AW-1:LW];
   assign off_raw  = addr_q[LW-1:0];
   assign amask    = LW'(lane_count(size_q) - 1);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign err     = |(off_raw & amask);
   assign off_eff = off_raw;
`else
   assign err     = 1'b0;
   assign off_eff = off_raw & ~amask;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         size_q  <= SIZE_B;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         if (accept) begin
            we_q    <= bus.writeEnable;
            sgn_q   <= bus.signedLoad;
            size_q  <= eff_size(bus.size, n);
            addr_q  <= bus.addr;
            wdata_q <= bus.writeData;
         end
         if (state_q == ACCESS) word_q <= mem_q[word_idx];
      end
   end

   dmem_lane_align #(.N(n), .LW(LW)) u_align (
      .size_i   (size_q),
      .off_i    (off_eff),
      .signed_i (sgn_q),
      .wdata_i  (wdata_q),
      .rword_i  (word_q),
      .wmask_o  (wmask),
      .wdata_o  (wdata_sh),
      .rdata_o  (load_data)
   );

   // A reset during ACCESS forces IDLE immediately, so the store never lands.
   assign mem_we = (state_q == ACCESS) && we_q && !err;

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (wmask[b]) mem_q[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

   assign bus.reqReady  = (state_q == IDLE);
   assign bus.respValid = (state_q == RESP);
   assign bus.respErr   = (state_q == RESP) && err;
   assign bus.readData  = ((state_q == RESP) && !we_q && !err) ? load_data : '0;

endmodule

// File: tb/tb_dmem_sized.sv
// tb/tb_dmem_sized.sv - self-checking bench for dmem_sized
module tb_dmem_sized;
   localparam int N  = 32;
   localparam int R  = 6;
   localparam int AW = R + $clog2(N / 8);

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mref [2**AW];

   always #5 clk = ~clk;

   dmem_sized_if #(.N(N), .R(R)) bus ();

   dmem_sized #(.n(N), .r(R)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   function automatic int nbytes(logic [1:0] sz);
      return (sz == 2'd3) ? 4 : (1 << sz);
   endfunction

   function automatic logic ref_err(logic [AW-1:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
      return (int'(a) % nbytes(sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int base_addr(logic [AW-1:0] a, logic [1:0] sz);
      return int'(a) - (int'(a) % nbytes(sz));
   endfunction

   function automatic logic [N-1:0] ref_load(logic [AW-1:0] a, logic [1:0] sz, logic sg);
      logic [63:0] v;
      int b, ba;
      b  = nbytes(sz);
      ba = base_addr(a, sz);
      if (ref_err(a, sz)) return '0;
      v = 64'd0;
      for (int i = 0; i < b; i++) v = v | (64'(mref[ba + i]) << (8 * i));
      if (sg && v[8*b-1]) v = v | (~64'd0 << (8 * b));
      return v[N-1:0];
   endfunction

   task automatic ref_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [N-1:0] wd);
      int b, ba;
      b  = nbytes(sz);
      ba = base_addr(a, sz);
      if (!ref_err(a, sz))
         for (int i = 0; i < b; i++) mref[ba + i] = wd[8*i +: 8];
   endtask

   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [N-1:0] wd,
                         output logic [N-1:0] rd, output logic er);
      int w;
      rd = '0;
      er = 1'b0;
      @(negedge clk);
      bus.writeEnable = we;
      bus.size        = sz;
      bus.signedLoad  = sg;
      bus.addr        = a;
      bus.writeData   = wd;
      bus.reqValid    = 1'b1;
      w = 0;
      while (bus.reqReady !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (bus.reqReady !== 1'b1) begin
         errors++;
         $display("FAIL req_accept_timeout: reqReady=%b required 1", bus.reqReady);
         bus.reqValid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.reqValid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.respValid !== 1'b0) begin
         errors++;
         $display("FAIL resp_early: respValid=%b required 0", bus.respValid);
      end
      @(negedge clk);
      checks++;
      if (bus.respValid !== 1'b1) begin
         errors++;
         $display("FAIL resp_latency: respValid=%b required 1", bus.respValid);
      end
      rd = bus.readData;
      er = bus.respErr;
      @(negedge clk);
      checks++;
      if (bus.respValid !== 1'b0) begin
         errors++;
         $display("FAIL resp_pulse_width: respValid=%b required 0", bus.respValid);
      end
   endtask

   task automatic do_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [N-1:0] wd);
      logic [N-1:0] rd;
      logic er, exp_er;
      exp_er = ref_err(a, sz);
      do_req(1'b1, sz, 1'b0, a, wd, rd, er);
      checks++;
      if (rd !== '0 || er !== exp_er) begin
         errors++;
         $display("FAIL store_ack @%h: readData=%h respErr=%b required 0 / %b", a, rd, er, exp_er);
      end
      ref_store(a, sz, wd);
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [1:0] sz, input logic sg,
                          input logic [N-1:0] exp, input string name);
      logic [N-1:0] rd;
      logic er, exp_er;
      exp_er = ref_err(a, sz);
      do_req(1'b0, sz, sg, a, '0, rd, er);
      checks++;
      if (rd !== exp || er !== exp_er) begin
         errors++;
         $display("FAIL %s @%h: readData=%h respErr=%b required %h / %b", name, a, rd, er, exp, exp_er);
      end
   endtask

   task automatic test_reset();
      bus.reqValid = 1'b0; bus.writeEnable = 1'b0; bus.size = 2'b00;
      bus.signedLoad = 1'b0; bus.addr = '0; bus.writeData = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0 || bus.readData !== '0 || bus.respErr !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b required 1 0 0 0",
                  bus.reqReady, bus.respValid, bus.readData, bus.respErr);
      end
   endtask

   task automatic test_init();
      for (int i = 0; i < 2**R; i++) do_store(AW'(i * 4), 2'b10, N'($urandom));
   endtask

   task automatic test_word();
      do_store(8'h54, 2'b10, 32'hDEADBEEF);
      do_load(8'h54, 2'b10, 1'b0, 32'hDEADBEEF, "load_word");
   endtask

   task automatic test_byte();
      do_store(8'h55, 2'b00, 32'h000000AC);
      do_load(8'h54, 2'b10, 1'b0, 32'hDEADACEF, "word_after_byte_store");
      do_load(8'h55, 2'b00, 1'b1, 32'hFFFFFFAC, "load_byte_signed");
      do_load(8'h55, 2'b00, 1'b0, 32'h000000AC, "load_byte_unsigned");
   endtask

   task automatic test_half();
      do_load(8'h56, 2'b01, 1'b1, 32'hFFFFDEAD, "load_half_signed");
      do_load(8'h56, 2'b01, 1'b0, 32'h0000DEAD, "load_half_unsigned");
      do_store(8'h54, 2'b01, 32'h00001234);
      do_load(8'h54, 2'b10, 1'b0, 32'hDEAD1234, "word_after_half_store");
      do_load(8'h54, 2'b11, 1'b0, 32'hDEAD1234, "dword_as_word");
   endtask

   task automatic test_misalign();
      do_store(8'h56, 2'b10, 32'hBCBCBCBC);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_load(8'h54, 2'b10, 1'b0, 32'hDEAD1234, "misaligned_store_trapped");
      do_load(8'h55, 2'b01, 1'b0, 32'h00000000, "misaligned_load_trapped");
`else
      do_load(8'h54, 2'b10, 1'b0, 32'hBCBCBCBC, "misaligned_store_aligned_down");
      do_load(8'h57, 2'b01, 1'b0, 32'h0000BCBC, "misaligned_half_aligned_down");
`endif
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp;
      exp = ref_load(8'h54, 2'b10, 1'b0);
      @(negedge clk);
      bus.writeEnable = 1'b0; bus.size = 2'b10; bus.signedLoad = 1'b0;
      bus.addr = 8'h54; bus.reqValid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (bus.reqReady !== (k % 3 == 0) || bus.respValid !== (k % 3 == 2)) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: ready=%b valid=%b required %b %b",
                     k, bus.reqReady, bus.respValid, (k % 3 == 0), (k % 3 == 2));
         end
         if (k % 3 == 2) begin
            checks++;
            if (bus.readData !== exp) begin
               errors++;
               $display("FAIL back_to_back_data cycle %0d: readData=%h required %h", k, bus.readData, exp);
            end
         end
         @(negedge clk);
      end
      bus.reqValid = 1'b0;
   endtask

   task automatic test_reset_access();
      logic [N-1:0] exp;
      exp = ref_load(8'h3C, 2'b10, 1'b0);
      @(negedge clk);
      bus.writeEnable = 1'b1; bus.size = 2'b10; bus.signedLoad = 1'b0;
      bus.addr = 8'h3C; bus.writeData = 32'h11111111; bus.reqValid = 1'b1;
      @(posedge clk);
      #1 bus.reqValid = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0 || bus.readData !== '0) begin
         errors++;
         $display("FAIL reset_in_access_state: ready=%b valid=%b data=%h required 1 0 0",
                  bus.reqReady, bus.respValid, bus.readData);
      end
      do_load(8'h3C, 2'b10, 1'b0, exp, "store_suppressed_by_reset");
   endtask

   task automatic test_reset_resp();
      int seen;
      @(negedge clk);
      bus.writeEnable = 1'b0; bus.size = 2'b10; bus.addr = 8'h10; bus.reqValid = 1'b1;
      @(posedge clk);
      #1 bus.reqValid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.respValid !== 1'b0 || bus.readData !== '0) begin
         errors++;
         $display("FAIL reset_in_resp: valid=%b data=%h required 0 0", bus.respValid, bus.readData);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.respValid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL dropped_response: respValid pulses=%0d required 0", seen);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [1:0]    sz;
      logic          sg;
      for (int i = 0; i < 120; i++) begin
         a  = AW'($urandom);
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom);
         if ($urandom_range(0, 1) == 1) do_store(a, sz, N'($urandom));
         else do_load(a, sz, sg, ref_load(a, sz, sg), "random_load");
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_back_to_back();
      test_reset_access();
      test_reset_resp();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
